// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the 4x4 int8 tensor core and its stream controller.
package tensor_core_pkg;

  localparam int unsigned BUS_WIDTH = 8;
  localparam int unsigned DIM       = 4;
  localparam int unsigned ELEMS     = DIM * DIM;
  localparam int unsigned IDX_W     = $clog2(ELEMS);
  localparam int unsigned RC_W      = $clog2(DIM);

  typedef logic signed [BUS_WIDTH-1:0] element_t;
  typedef element_t [DIM-1:0][DIM-1:0] matrix_t;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    CAPTURE,
    DRAIN
  } ctrl_state_t;

  typedef struct packed {
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
  } rc_t;

  // Row-major linear element index -> (row, col).
  function automatic rc_t idx_to_rc(input logic [IDX_W-1:0] idx);
    rc_t rc;
    rc.row = RC_W'(idx / IDX_W'(DIM));
    rc.col = RC_W'(idx % IDX_W'(DIM));
    return rc;
  endfunction

endpackage

// File: rtl/tensor_core_stream_controller.sv
// Loads A and B from a byte stream, launches the tensor core, waits for done,
// then streams the 16 result elements out row-major with valid/ready.
module tensor_core_stream_controller
  import tensor_core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic     clock_in,
  input  logic     reset_n_in,
  input  element_t in_data,
  input  logic     in_valid,
  output logic     in_ready,
  output element_t out_data,
  output logic     out_valid,
  input  logic     out_ready,
  output logic     out_last,
  output matrix_t  tensor_core_input1,
  output matrix_t  tensor_core_input2,
  output logic     tensor_core_register_file_write_enable,
  input  matrix_t  tensor_core_output,
  input  logic     is_done_with_calculation,
  output logic     busy,
  output logic     timeout_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ctrl_state_t      r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_wait_cnt;
  matrix_t          r_mat_a;
  matrix_t          r_mat_b;
  matrix_t          r_result;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_last;
  element_t         r_out_data;
  logic             r_we;
  logic             r_busy;
  logic             r_timeout;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_idx_last;
  logic             w_wait_expired;
  rc_t              w_cur_rc;
  rc_t              w_next_rc;

  assign w_in_fire      = in_valid && r_in_ready;
  assign w_out_fire     = r_out_valid && out_ready;
  assign w_idx_last     = (r_idx == IDX_W'(ELEMS - 1));
  assign w_wait_expired = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_cur_rc       = idx_to_rc(r_idx);
  assign w_next_rc      = idx_to_rc(r_idx + IDX_W'(1));

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= LOAD_A;
      r_idx       <= '0;
      r_wait_cnt  <= '0;
      r_mat_a     <= '0;
      r_mat_b     <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        LOAD_A: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_mat_a[w_cur_rc.row][w_cur_rc.col] <= in_data;
            r_busy <= 1'b1;
            if (w_idx_last) begin
              r_idx   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (w_in_fire) begin
            r_mat_b[w_cur_rc.row][w_cur_rc.col] <= in_data;
            if (w_idx_last) begin
              r_idx      <= '0;
              r_in_ready <= 1'b0;
              r_we       <= 1'b1;
              r_state    <= START;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        START: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          // Count zero is the first WAIT cycle, where done may be left over from the last job.
          if ((r_wait_cnt != '0) && is_done_with_calculation) begin
            r_state <= CAPTURE;
          end else if (w_wait_expired) begin
            r_timeout  <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= LOAD_A;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          r_result    <= tensor_core_output;
          r_idx       <= '0;
          r_out_valid <= 1'b1;
          r_out_data  <= tensor_core_output[0][0];
          r_out_last  <= 1'b0;
          r_state     <= DRAIN;
        end
        DRAIN: begin
          if (w_out_fire) begin
            if (w_idx_last) begin
              r_idx       <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= LOAD_A;
            end else begin
              r_idx      <= r_idx + IDX_W'(1);
              r_out_data <= r_result[w_next_rc.row][w_next_rc.col];
              r_out_last <= (r_idx == IDX_W'(ELEMS - 2));
            end
          end
        end
        default: begin
          r_state <= LOAD_A;
        end
      endcase
    end
  end

  assign in_ready                               = r_in_ready;
  assign out_data                               = r_out_data;
  assign out_valid                              = r_out_valid;
  assign out_last                               = r_out_last;
  assign tensor_core_input1                     = r_mat_a;
  assign tensor_core_input2                     = r_mat_b;
  assign tensor_core_register_file_write_enable = r_we;
  assign busy                                   = r_busy;
  assign timeout_error                          = r_timeout;

endmodule

// File: tb/tb_tensor_core_stream_controller.sv
// Bench for tensor_core_stream_controller: behavioural core model, matrix-product
// scoreboard on the output stream, randomized gaps/stalls, timeout and reset cases.
module tb_tensor_core_stream_controller;
  import tensor_core_pkg::*;

  logic     clock_in = 1'b0;
  logic     reset_n_in = 1'b0;
  element_t in_data = '0;
  logic     in_valid = 1'b0;
  logic     in_ready;
  element_t out_data;
  logic     out_valid;
  logic     out_ready = 1'b0;
  logic     out_last;
  matrix_t  tc_in1;
  matrix_t  tc_in2;
  logic     tc_we;
  matrix_t  core_out = '0;
  logic     core_done = 1'b0;
  logic     busy;
  logic     timeout_error;

  tensor_core_stream_controller #(.TIMEOUT_CYCLES(64)) dut (
    .clock_in                               (clock_in),
    .reset_n_in                             (reset_n_in),
    .in_data                                (in_data),
    .in_valid                               (in_valid),
    .in_ready                               (in_ready),
    .out_data                               (out_data),
    .out_valid                              (out_valid),
    .out_ready                              (out_ready),
    .out_last                               (out_last),
    .tensor_core_input1                     (tc_in1),
    .tensor_core_input2                     (tc_in2),
    .tensor_core_register_file_write_enable (tc_we),
    .tensor_core_output                     (core_out),
    .is_done_with_calculation               (core_done),
    .busy                                   (busy),
    .timeout_error                          (timeout_error)
  );

  always #5 clock_in = ~clock_in;

  int         n_pass = 0;
  int         n_checks = 0;
  int         ja[16];
  int         jb[16];
  logic [7:0] exp_q[$];
  int         stall_pct = 0;
  int         gap_pct = 0;
  bit         core_never = 1'b0;
  int         core_stage = 0;
  int         core_cnt = 0;
  int         n_we = 0;
  int         n_in_hs = 0;
  int         n_out_hs = 0;
  int         out_cnt = 0;
  bit         prev_stall = 1'b0;
  element_t   prev_data = '0;
  logic [7:0] cmp_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], truncated to 8 bits.
  function automatic logic [7:0] mm(input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += ja[i*4+k] * jb[k*4+j];
    return 8'(s);
  endfunction

  function automatic matrix_t pack_m(input bit sel_b);
    matrix_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = 8'(sel_b ? jb[r*4+c] : ja[r*4+c]);
    return m;
  endfunction

  function automatic matrix_t core_mul(input matrix_t a, input matrix_t b);
    matrix_t r;
    int s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(a[i][k]) * int'(b[k][j]);
        r[i][j] = 8'(s);
      end
    return r;
  endfunction

  // Core model: done stays stale for one cycle after launch, drops, then rises after a random latency.
  always @(posedge clock_in) begin
    if (tc_we) begin
      core_stage <= 1;
    end else if (core_stage == 1) begin
      core_done  <= 1'b0;
      core_cnt   <= int'($urandom_range(0, 6));
      core_stage <= 2;
    end else if (core_stage == 2 && !core_never) begin
      if (core_cnt == 0) begin
        core_done  <= 1'b1;
        core_out   <= core_mul(tc_in1, tc_in2);
        core_stage <= 0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  initial forever begin
    @(posedge clock_in);
    #1;
    out_ready = ($urandom_range(0, 99) >= stall_pct);
  end

  // Compare process: output stream vs scoreboard, hold-while-stalled, launch operands.
  initial forever begin
    @(negedge clock_in);
    if (!reset_n_in) begin
      prev_stall = 1'b0;
      out_cnt    = 0;
    end else begin
      if (exp_q.size() == 0) check("no_out_valid_when_idle", {31'b0, out_valid}, 0);
      if (!out_valid) check("out_last_without_valid", {31'b0, out_last}, 0);
      if (prev_stall) begin
        check("out_valid_held", {31'b0, out_valid}, 1);
        check("out_data_held", {24'b0, out_data}, {24'b0, prev_data});
      end
      if (out_valid && out_ready) begin
        n_out_hs++;
        if (exp_q.size() != 0) begin
          cmp_exp = exp_q.pop_front();
          check("out_data", {24'b0, out_data}, {24'b0, cmp_exp});
          check("out_last", {31'b0, out_last}, 32'(out_cnt == 15));
          out_cnt = (out_cnt + 1) % 16;
        end
      end
      if (in_valid && in_ready) n_in_hs++;
      if (tc_we) begin
        n_we++;
        check("operand_a_at_launch", 32'(tc_in1 == pack_m(1'b0)), 1);
        check("operand_b_at_launch", 32'(tc_in2 == pack_m(1'b1)), 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic load_job(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0: begin ja[i] = (i / 4 == i % 4) ? 1 : 0; jb[i] = i; end
        1: begin ja[i] = 2;   jb[i] = 3;  end
        2: begin ja[i] = -1;  jb[i] = 1;  end
        3: begin ja[i] = 16;  jb[i] = 16; end
        default: begin
          ja[i] = int'($urandom_range(0, 255)) - 128;
          jb[i] = int'($urandom_range(0, 255)) - 128;
        end
      endcase
    end
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      bit acc;
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clock_in);
        #1;
      end
      in_valid = 1'b1;
      in_data  = 8'(i < 16 ? ja[i] : jb[i-16]);
      guard = 0;
      forever begin
        @(negedge clock_in);
        acc = in_ready;
        @(posedge clock_in);
        #1;
        if (acc) break;
        guard++;
        if (guard > 200) begin
          check("in_accept_bound", 0, 1);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input string tag, input int gap, input int stall);
    int we0, in0, out0, guard;
    gap_pct = gap;
    stall_pct = stall;
    we0 = n_we; in0 = n_in_hs; out0 = n_out_hs;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_q.push_back(mm(i, j));
    send_bytes(32);
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge clock_in);
      guard++;
    end
    check({tag, "_all_outputs_seen"}, 32'(exp_q.size()), 0);
    @(negedge clock_in);
    check({tag, "_in_ready_after"}, {31'b0, in_ready}, 1);
    check({tag, "_busy_after"}, {31'b0, busy}, 0);
    check({tag, "_timeout_clear"}, {31'b0, timeout_error}, 0);
    check({tag, "_we_pulses"}, 32'(n_we - we0), 1);
    check({tag, "_in_handshakes"}, 32'(n_in_hs - in0), 32);
    check({tag, "_out_handshakes"}, 32'(n_out_hs - out0), 16);
    exp_q.delete();
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clock_in);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_last", {31'b0, out_last}, 0);
    check("rst_we", {31'b0, tc_we}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_timeout", {31'b0, timeout_error}, 0);
    check("rst_mat_a", 32'(tc_in1 == '0), 1);
    @(posedge clock_in); #1;
    reset_n_in = 1'b1;
    @(posedge clock_in); #1;
    @(negedge clock_in);
    check("post_rst_in_ready", {31'b0, in_ready}, 1);
    check("post_rst_busy", {31'b0, busy}, 0);
    @(posedge clock_in); #1;

    load_job(0);
    check("model_identity", {24'b0, mm(2, 3)}, 32'd11);
    run_job("identity", 0, 0);
    load_job(1);
    check("model_2x3", {24'b0, mm(3, 3)}, 32'h18);
    run_job("twos_threes", 0, 0);
    load_job(2);
    check("model_neg", {24'b0, mm(1, 2)}, 32'hFC);
    run_job("neg_ones", 0, 0);
    load_job(3);
    check("model_wrap", {24'b0, mm(2, 1)}, 32'h00);
    run_job("wrap16", 0, 0);
    load_job(9);
    run_job("random_nostall", 0, 0);
    run_job("random_stall", 50, 50);
    load_job(9);
    run_job("random2_stall", 50, 50);

    // Core never finishes: expect exactly 64 WAIT cycles, then sticky timeout.
    core_never = 1'b1;
    gap_pct = 0;
    stall_pct = 0;
    load_job(9);
    send_bytes(32);
    guard = 0;
    do begin
      @(negedge clock_in);
      guard++;
    end while (!tc_we && guard < 50);
    check("to_launch_seen", {31'b0, tc_we}, 1);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock_in);
      check("to_not_yet", {31'b0, timeout_error}, 0);
      check("to_in_ready_low", {31'b0, in_ready}, 0);
      check("to_busy", {31'b0, busy}, 1);
    end
    @(negedge clock_in);
    check("to_raised", {31'b0, timeout_error}, 1);
    check("to_in_ready_back", {31'b0, in_ready}, 1);
    check("to_busy_low", {31'b0, busy}, 0);
    repeat (3) @(negedge clock_in);
    check("to_sticky", {31'b0, timeout_error}, 1);
    core_never = 1'b0;
    @(posedge clock_in); #1;

    // Partial load then reset: A must be cleared and a fresh job must be correct.
    load_job(9);
    send_bytes(10);
    reset_n_in = 1'b0;
    @(negedge clock_in);
    check("mid_rst_mat_a", 32'(tc_in1 == '0), 1);
    check("mid_rst_in_ready", {31'b0, in_ready}, 0);
    check("mid_rst_timeout", {31'b0, timeout_error}, 0);
    @(posedge clock_in); #1;
    reset_n_in = 1'b1;
    @(posedge clock_in); #1;
    @(negedge clock_in);
    check("after_rst_mat_a", 32'(tc_in1 == '0), 1);
    @(posedge clock_in); #1;
    load_job(9);
    run_job("after_reset", 20, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
